// File: rtl/pulse_rx_counter.sv
// -----------------------------------------------------------------------------
// pulse_rx_counter
//
// Counts rising edges on an asynchronous pulse input while the gate FSM is in
// S_RUN. On request the count is snapshotted and streamed MSB byte first over a
// byte-wide req/ack handshake.
//
// Optional feature: define PULSE_RX_DEADTIME_EN to ignore edges for P_DEADTIME
// cycles after every counted edge. Without the macro every qualified edge
// counts and P_DEADTIME has no effect.
//
// Parameters
//   P_CNT_W     counter width, multiple of 8 in 8..32 (N_BYTES = P_CNT_W/8)
//   P_DEADTIME  edge lockout length in cycles (>= 1)
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   pulse_in       asynchronous pulse input
//   run            level, leave S_IDLE and start counting
//   clr            level, stop counting and zero the counter (wins over run)
//   rd_start       one-cycle request to snapshot and stream the count
//   cnt_byte_req   byte valid toward the consumer
//   cnt_byte_ack   consumer accepts the current byte (same cycle as req)
//   cnt_byte_data  current byte, MSB byte first, 0 while req is low
//   running        gate FSM is in S_RUN
//   saturated      counter is at its maximum (combinational)
//   rd_busy        readout in progress
// -----------------------------------------------------------------------------
module pulse_rx_counter #(
  parameter int P_CNT_W    = 32,
  parameter int P_DEADTIME = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pulse_in,
  input  logic       run,
  input  logic       clr,
  input  logic       rd_start,
  output logic       cnt_byte_req,
  input  logic       cnt_byte_ack,
  output logic [7:0] cnt_byte_data,
  output logic       running,
  output logic       saturated,
  output logic       rd_busy
);

  localparam int N_BYTES = P_CNT_W / 8;
  localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_BYTES - 1);
  localparam logic [P_CNT_W-1:0] CNT_MAX  = '1;

  if ((P_CNT_W % 8) != 0 || P_CNT_W < 8 || P_CNT_W > 32 || P_DEADTIME < 1) begin : g_param_check
    $error("pulse_rx_counter: unsupported P_CNT_W/P_DEADTIME");
  end

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} gate_t;
  typedef enum logic {RD_IDLE = 1'b0, RD_SEND = 1'b1} rd_t;

  // Select byte i (0 = least significant) of a counter-wide value.
  function automatic logic [7:0] byte_of(input logic [P_CNT_W-1:0] v,
                                         input logic [IDX_W-1:0]   i);
    byte_of = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      if (i == IDX_W'(b)) byte_of = v[b*8 +: 8];
    end
  endfunction

  logic               s1, s2, s3;
  logic               rise;
  gate_t              state, state_nxt;
  logic               count_en;
  logic               locked;
  logic               inc;
  logic [P_CNT_W-1:0] counter;

  rd_t                rd_state, rd_nxt;
  logic [P_CNT_W-1:0] snapshot, snap_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [7:0]         data_nxt;
  logic               req_nxt;
  logic               xfer;

  // ---- input synchronizer and edge detect ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pulse_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // ---- gate FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run && !clr) state_nxt = S_RUN;
      S_RUN:   if (clr)         state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    running  = (state == S_RUN);
    count_en = (state == S_RUN) && !clr;
  end

  // ---- optional edge lockout ----
`ifdef PULSE_RX_DEADTIME_EN
  localparam int LOCK_W = $clog2(P_DEADTIME + 1);
  logic [LOCK_W-1:0] lock;

  assign locked = (lock != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lock <= '0;
    else if (clr)    lock <= '0;
    else if (inc)    lock <= LOCK_W'(P_DEADTIME);
    else if (locked) lock <= lock - LOCK_W'(1);
  end
`else
  assign locked = 1'b0;
`endif

  // ---- counter ----
  assign saturated = (counter == CNT_MAX);
  assign inc       = count_en & rise & ~locked & ~saturated;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   counter <= '0;
    else if (clr) counter <= '0;
    else if (inc) counter <= counter + P_CNT_W'(1);
  end

  // ---- readout FSM ----
  // req is high exactly while in RD_SEND, so ack alone would suffice; the
  // explicit AND keeps the transfer condition readable.
  assign xfer = cnt_byte_req & cnt_byte_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state      <= RD_IDLE;
      snapshot      <= '0;
      idx           <= '0;
      cnt_byte_req  <= 1'b0;
      cnt_byte_data <= '0;
      rd_busy       <= 1'b0;
    end else begin
      rd_state      <= rd_nxt;
      snapshot      <= snap_nxt;
      idx           <= idx_nxt;
      cnt_byte_req  <= req_nxt;
      cnt_byte_data <= data_nxt;
      rd_busy       <= req_nxt;
    end
  end

  always_comb begin
    rd_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (rd_start)             rd_nxt = RD_SEND;
      RD_SEND: if (xfer && idx == '0)    rd_nxt = RD_IDLE;
      default: rd_nxt = RD_IDLE;
    endcase
  end

  // Data is registered: the byte that will be presented next cycle is chosen
  // here, so the snapshot taken on rd_start feeds the first byte directly.
  always_comb begin
    snap_nxt = snapshot;
    idx_nxt  = idx;
    data_nxt = cnt_byte_data;
    case (rd_state)
      RD_IDLE: begin
        if (rd_start) begin
          snap_nxt = counter;
          idx_nxt  = IDX_LAST;
          data_nxt = byte_of(counter, IDX_LAST);
        end
      end
      RD_SEND: begin
        if (xfer) begin
          if (idx == '0) begin
            data_nxt = '0;
          end else begin
            idx_nxt  = idx - IDX_W'(1);
            data_nxt = byte_of(snapshot, idx - IDX_W'(1));
          end
        end
      end
      default: data_nxt = '0;
    endcase
    req_nxt = (rd_nxt == RD_SEND);
  end

endmodule

// File: tb/tb_pulse_rx_counter.sv
`timescale 1ns/1ps
module tb_pulse_rx_counter;

  localparam int DT = 4;
`ifdef PULSE_RX_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulse_in = 1'b0, run = 1'b0, clr = 1'b0, rd_start = 1'b0;
  logic ack32 = 1'b0, ack8 = 1'b0;
  logic req32, req8, running32, running8, sat32, sat8, busy32, busy8;
  logic [7:0] data32, data8;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model: number of pulses that the gate should have accepted.
  longint exp_cnt   = 0;
  bit     model_run = 1'b0;
  int     last_cnt  = -1000;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_rx_counter #(.P_CNT_W(32), .P_DEADTIME(DT)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .run(run), .clr(clr),
    .rd_start(rd_start), .cnt_byte_req(req32), .cnt_byte_ack(ack32),
    .cnt_byte_data(data32), .running(running32), .saturated(sat32), .rd_busy(busy32));

  pulse_rx_counter #(.P_CNT_W(8), .P_DEADTIME(DT)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .run(run), .clr(clr),
    .rd_start(rd_start), .cnt_byte_req(req8), .cnt_byte_ack(ack8),
    .cnt_byte_data(data8), .running(running8), .saturated(sat8), .rd_busy(busy8));

  function automatic logic [31:0] exp32();
    return exp_cnt[31:0];
  endfunction

  function automatic logic [7:0] exp8();
    return (exp_cnt > 255) ? 8'hFF : exp_cnt[7:0];
  endfunction

  // Pulses with random high/low phase lengths; the model counts a pulse when
  // the gate is open and, with lockout enabled, when more than DT cycles have
  // passed since the previous counted pulse.
  task automatic send_pulses(input int n, input int hmin, input int hmax,
                             input int lmin, input int lmax);
    for (int i = 0; i < n; i++) begin
      int hi, lo;
      hi = $urandom_range(hmax, hmin);
      lo = $urandom_range(lmax, lmin);
      @(posedge clk); #1;
      pulse_in = 1'b1;
      if (model_run && (!DT_EN || (cyc - last_cnt) > DT)) begin
        exp_cnt++;
        last_cnt = cyc;
      end
      repeat (hi) @(posedge clk);
      #1 pulse_in = 1'b0;
      repeat (lo - 1) @(posedge clk);
    end
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic do_run();
    @(posedge clk); #1 run = 1'b1;
    @(posedge clk); #1 run = 1'b0;
    model_run = 1'b1;
  endtask

  task automatic do_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    model_run = 1'b0;
    exp_cnt   = 0;
    last_cnt  = -1000;
  endtask

  // Runs one readout on both DUTs and returns the assembled values plus a count
  // of handshake violations (req dropping before ack, data changing while
  // stalled, busy/req/data wrong outside a stream).
  task automatic do_read(input int stall_byte, input int stall_len, input bit rnd_stall,
                         input bit restart, output logic [31:0] v32, output logic [7:0] v8,
                         output int perr, output bit tmo);
    int got32, got8, st32, st8, it;
    bit held32, held8, stall;
    logic [7:0] hold32, hold8;
    got32 = 0; got8 = 0; st32 = 0; st8 = 0; it = 0;
    held32 = 0; held8 = 0; hold32 = '0; hold8 = '0;
    v32 = '0; v8 = '0; perr = 0; tmo = 0;
    @(posedge clk); #1 rd_start = 1'b1;
    @(posedge clk); #1 rd_start = 1'b0;
    while ((got32 < 4 || got8 < 1) && it < 300) begin
      rd_start = (restart && it == 0);
      ack32 = 1'b0;
      if (got32 < 4) begin
        if (req32 !== 1'b1 || busy32 !== 1'b1) perr++;
        else begin
          if (held32 && data32 !== hold32) perr++;
          stall = (restart && it == 0) || (got32 == stall_byte && st32 < stall_len) ||
                  (rnd_stall && $urandom_range(3, 0) == 0);
          if (stall) begin held32 = 1; hold32 = data32; st32++; end
          else begin ack32 = 1'b1; v32 = {v32[23:0], data32}; got32++; held32 = 0; st32 = 0; end
        end
      end else if (req32 !== 1'b0 || busy32 !== 1'b0 || data32 !== 8'h00) perr++;
      ack8 = 1'b0;
      if (got8 < 1) begin
        if (req8 !== 1'b1 || busy8 !== 1'b1) perr++;
        else begin
          if (held8 && data8 !== hold8) perr++;
          stall = (restart && it == 0) || (got8 == stall_byte && st8 < stall_len) ||
                  (rnd_stall && $urandom_range(3, 0) == 0);
          if (stall) begin held8 = 1; hold8 = data8; st8++; end
          else begin ack8 = 1'b1; v8 = data8; got8++; held8 = 0; st8 = 0; end
        end
      end else if (req8 !== 1'b0 || busy8 !== 1'b0 || data8 !== 8'h00) perr++;
      @(posedge clk); #1;
      it++;
    end
    ack32 = 1'b0; ack8 = 1'b0; rd_start = 1'b0;
    if (it >= 300) tmo = 1;
    repeat (3) begin
      if (req32 !== 1'b0 || req8 !== 1'b0 || busy32 !== 1'b0 || busy8 !== 1'b0 ||
          data32 !== 8'h00 || data8 !== 8'h00) perr++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #35;
    n_total++;
    if ({req32, req8, busy32, busy8, running32, running8, sat32, sat8} !== 8'h00 ||
        data32 !== 8'h00 || data8 !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs got req=%b%b busy=%b%b run=%b%b sat=%b%b d=%h/%h req=0",
               req32, req8, busy32, busy8, running32, running8, sat32, sat8, data32, data8);
    end
    @(negedge clk) rst_n = 1'b1;
    settle();
  endtask

  task automatic test_basic_count();
    logic [31:0] v32; logic [7:0] v8; int perr; bit tmo;
    do_read(-1, 0, 0, 0, v32, v8, perr, tmo);
    n_total++;
    if (v32 !== 32'd0 || v8 !== 8'd0 || tmo) begin
      n_bad++; $display("FAIL post_reset_read got=%0d/%0d tmo=%0d exp=0", v32, v8, tmo);
    end
    do_run();
    send_pulses(10, 4, 4, 4, 4);
    settle();
    n_total++;
    if (running32 !== 1'b1 || running8 !== 1'b1) begin
      n_bad++; $display("FAIL running_after_run got=%b/%b exp=1", running32, running8);
    end
    do_read(-1, 0, 0, 0, v32, v8, perr, tmo);
    n_total++;
    if (v32 !== exp32() || v8 !== exp8() || perr != 0 || tmo) begin
      n_bad++;
      $display("FAIL count10 got=%0d/%0d exp=%0d/%0d perr=%0d tmo=%0d",
               v32, v8, exp32(), exp8(), perr, tmo);
    end
  endtask

  task automatic test_random_readout();
    logic [31:0] v32; logic [7:0] v8; int perr; bit tmo;
    for (int k = 0; k < 2; k++) begin
      do_clr();
      do_run();
      send_pulses($urandom_range(700, 300), 3, 5, 3, 5);
      settle();
      do_read(-1, 0, 1, 0, v32, v8, perr, tmo);
      n_total++;
      if (v32 !== exp32() || perr != 0 || tmo) begin
        n_bad++; $display("FAIL rand_read32 got=%h exp=%h perr=%0d tmo=%0d", v32, exp32(), perr, tmo);
      end
      n_total++;
      if (v8 !== exp8() || sat8 !== 1'b1 || sat32 !== 1'b0) begin
        n_bad++; $display("FAIL rand_read8 got=%h sat=%b/%b exp=%h sat=0/1", v8, sat32, sat8, exp8());
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] v32, e32; logic [7:0] v8, e8; int perr; bit tmo;
    e32 = exp32(); e8 = exp8();
    fork
      do_read(1, 20, 0, 0, v32, v8, perr, tmo);
      begin repeat (4) @(posedge clk); send_pulses(3, 2, 3, 2, 3); end
    join
    n_total++;
    if (v32 !== e32 || v8 !== e8 || perr != 0 || tmo) begin
      n_bad++;
      $display("FAIL stall_snapshot got=%h/%h exp=%h/%h perr=%0d tmo=%0d", v32, v8, e32, e8, perr, tmo);
    end
    settle();
    do_read(-1, 0, 1, 0, v32, v8, perr, tmo);
    n_total++;
    if (v32 !== exp32() || v8 !== exp8() || perr != 0 || tmo) begin
      n_bad++; $display("FAIL stall_pulses_counted got=%h/%h exp=%h/%h", v32, v8, exp32(), exp8());
    end
  endtask

  task automatic test_saturation();
    logic [31:0] v32; logic [7:0] v8; int perr; bit tmo;
    do_clr();
    do_run();
    send_pulses(300, 3, 3, 3, 3);
    settle();
    do_read(-1, 0, 0, 0, v32, v8, perr, tmo);
    n_total++;
    if (v8 !== 8'hFF || sat8 !== 1'b1 || v32 !== exp32()) begin
      n_bad++; $display("FAIL sat_hold got=%h sat=%b cnt32=%0d exp=ff sat=1 cnt32=%0d", v8, sat8, v32, exp32());
    end
    do_clr();
    settle();
    do_read(-1, 0, 0, 0, v32, v8, perr, tmo);
    n_total++;
    if (v8 !== 8'h00 || v32 !== 32'd0 || sat8 !== 1'b0 || running8 !== 1'b0 || running32 !== 1'b0) begin
      n_bad++; $display("FAIL sat_clr got=%h/%h sat=%b run=%b exp=0 sat=0 run=0", v32, v8, sat8, running8);
    end
    // One pulse short of saturation, then time the final increment.
    do_run();
    send_pulses(254, 3, 3, 3, 3);
    settle();
    @(posedge clk); #1 pulse_in = 1'b1;
    exp_cnt++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++;
    if (sat8 !== 1'b0) begin
      n_bad++; $display("FAIL latency_early got sat=%b after 2 clk exp=0", sat8);
    end
    @(posedge clk); #1;
    n_total++;
    if (sat8 !== 1'b1) begin
      n_bad++; $display("FAIL latency_3clk got sat=%b after 3 clk exp=1", sat8);
    end
    repeat (2) @(posedge clk);
    #1 pulse_in = 1'b0;
    settle();
  endtask

  task automatic test_controls();
    logic [31:0] v32, e32; logic [7:0] v8; int perr; bit tmo;
    do_clr();
    @(posedge clk); #1 run = 1'b1; clr = 1'b1;
    @(posedge clk); #1 run = 1'b0; clr = 1'b0;
    send_pulses(5, 3, 4, 3, 4);
    settle();
    n_total++;
    if (running32 !== 1'b0 || running8 !== 1'b0) begin
      n_bad++; $display("FAIL run_clr_same got running=%b/%b exp=0", running32, running8);
    end
    do_read(-1, 0, 0, 0, v32, v8, perr, tmo);
    n_total++;
    if (v32 !== 32'd0 || v8 !== 8'd0) begin
      n_bad++; $display("FAIL run_clr_count got=%0d/%0d exp=0", v32, v8);
    end
    do_run();
    send_pulses($urandom_range(40, 20), 3, 5, 3, 5);
    settle();
    do_read(-1, 0, 1, 1, v32, v8, perr, tmo);
    n_total++;
    if (v32 !== exp32() || v8 !== exp8() || perr != 0 || tmo) begin
      n_bad++;
      $display("FAIL rd_start_busy got=%0d/%0d exp=%0d/%0d perr=%0d tmo=%0d",
               v32, v8, exp32(), exp8(), perr, tmo);
    end
    e32 = exp32();
    fork
      do_read(1, 8, 0, 0, v32, v8, perr, tmo);
      begin repeat (3) @(posedge clk); #1 clr = 1'b1; @(posedge clk); #1 clr = 1'b0; end
    join
    model_run = 1'b0; exp_cnt = 0; last_cnt = -1000;
    n_total++;
    if (v32 !== e32 || perr != 0 || running32 !== 1'b0) begin
      n_bad++; $display("FAIL clr_mid_read got=%0d run=%b perr=%0d exp=%0d run=0", v32, running32, perr, e32);
    end
    do_run();
    send_pulses(6, 3, 4, 3, 4);
    settle();
    @(posedge clk); #1 rd_start = 1'b1;
    @(posedge clk); #1 rd_start = 1'b0;
    #5 rst_n = 1'b0;
    #1;
    n_total++;
    if ({req32, req8, busy32, busy8, running32, running8} !== 6'b0 ||
        data32 !== 8'h00 || data8 !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid_read got req=%b%b busy=%b%b run=%b%b d=%h/%h exp=0",
               req32, req8, busy32, busy8, running32, running8, data32, data8);
    end
    @(negedge clk) rst_n = 1'b1;
    model_run = 1'b0; exp_cnt = 0; last_cnt = -1000;
    settle();
    do_read(-1, 0, 0, 0, v32, v8, perr, tmo);
    n_total++;
    if (v32 !== 32'd0 || v8 !== 8'd0 || perr != 0 || tmo) begin
      n_bad++; $display("FAIL read_after_reset got=%0d/%0d exp=0 perr=%0d", v32, v8, perr);
    end
  endtask

  task automatic test_deadtime();
    logic [31:0] v32; logic [7:0] v8; int perr; bit tmo;
    do_clr();
    do_run();
    send_pulses(12, 2, 2, 2, 2);
    settle();
    do_read(-1, 0, 0, 0, v32, v8, perr, tmo);
    n_total++;
    if (v32 !== exp32() || v8 !== exp8()) begin
      n_bad++; $display("FAIL deadtime_fixed got=%0d/%0d exp=%0d/%0d", v32, v8, exp32(), exp8());
    end
    do_clr();
    do_run();
    send_pulses(20, 2, 3, 2, 3);
    settle();
    do_read(-1, 0, 1, 0, v32, v8, perr, tmo);
    n_total++;
    if (v32 !== exp32() || v8 !== exp8() || perr != 0) begin
      n_bad++; $display("FAIL deadtime_rand got=%0d/%0d exp=%0d/%0d", v32, v8, exp32(), exp8());
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_random_readout();
    test_stall();
    test_saturation();
    test_controls();
    test_deadtime();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
